poly_voice_engine: RTL and testbench

//  Parametrised polyphonic voice core; sits between the SPI note decoder and the DAC path.

---
 rtl/poly_voice_engine.sv | 191 +++++++++++++++++++
 tb/tb_poly_voice_engine.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_voice_engine.sv
// poly_voice_engine: polyphonic sawtooth voice core.
// Events allocate notes to NUM_VOICES slots; each sample tick the voices are swept one per
// clock, velocity-scaled, summed, saturated and strobed out.
// Optional feature macro: VOICE_STEAL_EN (round-robin voice stealing when all voices are busy).
module poly_voice_engine #(
  parameter int NUM_VOICES = 8,
  parameter int PHASE_W    = 24,
  parameter int OUT_W      = 16,
  parameter int CLK_DIV    = 1042
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      evt_valid,
  output logic                      evt_ready,
  input  logic                      evt_note_on,
  input  logic [6:0]                evt_note,
  input  logic [6:0]                evt_velocity,
  input  logic [PHASE_W-1:0]        evt_phase_inc,
  output logic signed [OUT_W-1:0]   sample_out,
  output logic                      sample_valid,
  output logic [NUM_VOICES-1:0]     active_voices,
  output logic                      note_dropped
);

  localparam int VW    = $clog2(NUM_VOICES);
  localparam int CW    = $clog2(CLK_DIV);
  localparam int ACC_W = 23 + VW;
  localparam int SHIFT = 7 + 16 - OUT_W;
  localparam int MAXV  = (1 << (OUT_W - 1)) - 1;
  localparam int MINV  = -(1 << (OUT_W - 1));

  typedef enum logic [1:0] {IDLE, SWEEP, SAT, OUT} state_t;

  state_t                   state, state_nxt;
  logic [CW-1:0]            cnt;
  logic                     tick;
  logic [VW-1:0]            vidx;
  logic signed [ACC_W-1:0]  acc;
  logic [PHASE_W-1:0]       phase [NUM_VOICES];
  logic [PHASE_W-1:0]       inc   [NUM_VOICES];
  logic [6:0]               vel   [NUM_VOICES];
  logic [6:0]               note  [NUM_VOICES];
  logic [NUM_VOICES-1:0]    active;

  logic                     hs, is_on, hit, free_any, alloc_ok;
  logic [VW-1:0]            hit_idx, free_idx, alloc_idx;
  logic [NUM_VOICES-1:0]    match_vec;
  logic signed [15:0]       saw;
  logic signed [23:0]       prod;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [OUT_W-1:0]  clamped;

  assign tick          = (cnt == CW'(CLK_DIV - 1));
  assign hs            = evt_valid && evt_ready;
  assign is_on         = evt_note_on && (evt_velocity != 7'd0);
  assign active_voices = active;

  // Free-running sample tick divider
  always_ff @(posedge clk) begin
    if (reset)     cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

  // Sequencer state register; ready is registered so it is low while reset is applied
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      evt_ready <= 1'b0;
    end else begin
      state     <= state_nxt;
      evt_ready <= (state_nxt == IDLE);
    end
  end

  // Sequencer next-state: IDLE -> SWEEP (one voice per clk) -> SAT -> OUT
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tick) state_nxt = SWEEP;
      SWEEP:   if (vidx == VW'(NUM_VOICES - 1)) state_nxt = SAT;
      SAT:     state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Lowest-index matching voice and lowest-index free voice (scan downward, last write wins)
  always_comb begin
    hit       = 1'b0;
    hit_idx   = '0;
    free_any  = 1'b0;
    free_idx  = '0;
    match_vec = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      match_vec[i] = active[i] && (note[i] == evt_note);
      if (match_vec[i]) begin
        hit     = 1'b1;
        hit_idx = VW'(i);
      end
      if (!active[i]) begin
        free_any = 1'b1;
        free_idx = VW'(i);
      end
    end
  end

`ifdef VOICE_STEAL_EN
  logic [VW-1:0] steal_ptr;

  assign alloc_ok     = 1'b1;
  assign alloc_idx    = hit ? hit_idx : (free_any ? free_idx : steal_ptr);
  assign note_dropped = 1'b0;

  // Round-robin victim pointer, advanced only when a voice is actually stolen
  always_ff @(posedge clk) begin
    if (reset)
      steal_ptr <= '0;
    else if (hs && is_on && !hit && !free_any)
      steal_ptr <= (steal_ptr == VW'(NUM_VOICES - 1)) ? '0 : steal_ptr + 1'b1;
  end
`else
  assign alloc_ok     = hit || free_any;
  assign alloc_idx    = hit ? hit_idx : free_idx;
  assign note_dropped = hs && is_on && !hit && !free_any && !reset;
`endif

  assign saw  = {~phase[vidx][PHASE_W-1], phase[vidx][PHASE_W-2 -: 15]};
  assign prod = 24'(saw) * 24'($signed({1'b0, vel[vidx]}));

  // Voice table, sweep accumulator and event application (events only land in IDLE)
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        phase[i] <= '0;
        inc[i]   <= '0;
        vel[i]   <= '0;
        note[i]  <= '0;
      end
      active <= '0;
      acc    <= '0;
      vidx   <= '0;
    end else begin
      if (state == IDLE && tick) begin
        acc  <= '0;
        vidx <= '0;
      end
      if (state == SWEEP) begin
        if (active[vidx]) begin
          acc         <= acc + ACC_W'(prod);
          phase[vidx] <= phase[vidx] + inc[vidx];
        end
        vidx <= vidx + 1'b1;
      end
      if (hs) begin
        if (is_on) begin
          if (alloc_ok) begin
            active[alloc_idx] <= 1'b1;
            note[alloc_idx]   <= evt_note;
            vel[alloc_idx]    <= evt_velocity;
            inc[alloc_idx]    <= evt_phase_inc;
            phase[alloc_idx]  <= '0;
          end
        end else begin
          for (int i = 0; i < NUM_VOICES; i++)
            if (match_vec[i]) active[i] <= 1'b0;
        end
      end
    end
  end

  // Scale the mix down to OUT_W and clamp to the signed output range
  always_comb begin
    shifted = acc >>> SHIFT;
    if (shifted > ACC_W'(MAXV))      clamped = OUT_W'(MAXV);
    else if (shifted < ACC_W'(MINV)) clamped = OUT_W'(MINV);
    else                             clamped = shifted[OUT_W-1:0];
  end

  // Sample register and strobe; strobe is high during OUT
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= (state == SAT);
      if (state == SAT) sample_out <= clamped;
    end
  end

endmodule

// File: tb/tb_poly_voice_engine.sv
// Self-checking bench for poly_voice_engine (NUM_VOICES=8, PHASE_W=24, OUT_W=16, CLK_DIV=16).
// Expected samples come from a behavioural voice model pushed into a queue and popped on strobes.
module tb_poly_voice_engine;
  localparam int NV = 8;
  localparam int PW = 24;
  localparam int OW = 16;
  localparam int CD = 16;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 evt_valid = 1'b0;
  logic                 evt_ready;
  logic                 evt_note_on = 1'b0;
  logic [6:0]           evt_note = '0;
  logic [6:0]           evt_velocity = '0;
  logic [PW-1:0]        evt_phase_inc = '0;
  logic signed [OW-1:0] sample_out;
  logic                 sample_valid;
  logic [NV-1:0]        active_voices;
  logic                 note_dropped;

  poly_voice_engine #(.NUM_VOICES(NV), .PHASE_W(PW), .OUT_W(OW), .CLK_DIV(CD)) dut (
    .clk(clk), .reset(reset), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_note_on(evt_note_on), .evt_note(evt_note), .evt_velocity(evt_velocity),
    .evt_phase_inc(evt_phase_inc), .sample_out(sample_out), .sample_valid(sample_valid),
    .active_voices(active_voices), .note_dropped(note_dropped)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  int q[$];

  bit            m_act  [NV];
  int            m_note [NV];
  int            m_vel  [NV];
  logic [PW-1:0] m_ph   [NV];
  logic [PW-1:0] m_inc  [NV];
  int            m_ptr;

  function automatic void model_reset();
    for (int i = 0; i < NV; i++) begin
      m_act[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_ph[i] = '0; m_inc[i] = '0;
    end
    m_ptr = 0;
  endfunction

  function automatic void model_event(bit on, int nt, int vl, logic [PW-1:0] pinc);
    int idx;
    idx = -1;
    if (on && vl != 0) begin
      for (int i = 0; i < NV; i++) if (idx < 0 && m_act[i] && m_note[i] == nt) idx = i;
      for (int i = 0; i < NV; i++) if (idx < 0 && !m_act[i]) idx = i;
`ifdef VOICE_STEAL_EN
      if (idx < 0) begin
        idx = m_ptr;
        m_ptr = (m_ptr + 1) % NV;
      end
`endif
      if (idx >= 0) begin
        m_act[idx] = 1; m_note[idx] = nt; m_vel[idx] = vl; m_inc[idx] = pinc; m_ph[idx] = '0;
      end
    end else begin
      for (int i = 0; i < NV; i++) if (m_act[i] && m_note[i] == nt) m_act[i] = 0;
    end
  endfunction

  // One sample of the model: sum of velocity-scaled saws, then advance phases
  function automatic int model_mix();
    longint acc;
    longint mix;
    logic signed [15:0] s;
    acc = 0;
    for (int i = 0; i < NV; i++) begin
      if (m_act[i]) begin
        s = {~m_ph[i][PW-1], m_ph[i][PW-2 -: 15]};
        acc += longint'(s) * m_vel[i];
        m_ph[i] = m_ph[i] + m_inc[i];
      end
    end
    mix = acc >>> 7;
    if (mix > 32767) mix = 32767;
    if (mix < -32768) mix = -32768;
    return int'(mix);
  endfunction

  task automatic do_reset();
    evt_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    q.delete();
  endtask

  task automatic send_evt(input bit on, input int nt, input int vl, input logic [PW-1:0] pinc,
                          output bit dropped);
    bit done;
    done = 0;
    dropped = 0;
    evt_note_on = on; evt_note = 7'(nt); evt_velocity = 7'(vl); evt_phase_inc = pinc;
    evt_valid = 1'b1;
    for (int g = 0; g < 50 && !done; g++) begin
      @(negedge clk);
      if (evt_ready) begin
        done = 1;
        dropped = note_dropped;
      end
      @(posedge clk); #1;
    end
    evt_valid = 1'b0;
    if (done) model_event(on, nt, vl, pinc);
    else begin
      n_cmp++; n_err++;
      $display("FAIL evt_accept: note %0d not accepted within 50 cycles, required accept", nt);
    end
  endtask

  task automatic wait_strobe(output bit ok);
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (sample_valid) ok = 1;
    end
  endtask

  task automatic test_reset();
    bit d;
    do_reset();
    send_evt(1, 60, 127, 24'h010000, d);
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (active_voices !== 8'h00) begin n_err++; $display("FAIL reset_active: got %h required 00", active_voices); end
    n_cmp++;
    if (sample_out !== 16'sd0 || sample_valid !== 1'b0 || note_dropped !== 1'b0 || evt_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got out=%0d valid=%b drop=%b ready=%b required all 0",
               sample_out, sample_valid, note_dropped, evt_ready);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_idle();
    bit ok;
    int prev, exp;
    do_reset();
    for (int k = 0; k < 3; k++) q.push_back(model_mix());
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      wait_strobe(ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL idle_strobe[%0d]: got timeout required strobe", k); end
      else begin
        exp = q.pop_front();
        if (int'(sample_out) !== exp || active_voices !== 8'h00) begin
          n_err++;
          $display("FAIL idle_sample[%0d]: got %0d/%h required %0d/00", k, sample_out, active_voices, exp);
        end
        if (k > 0) begin
          n_cmp++;
          if (cyc - prev !== CD) begin n_err++; $display("FAIL idle_period: got %0d required %0d", cyc - prev, CD); end
        end
        prev = cyc;
      end
    end
  endtask

  task automatic test_single_ramp();
    bit ok, d;
    int exp;
    do_reset();
    send_evt(1, 60, 127, 24'h010000, d);
    n_cmp++;
    if (active_voices !== 8'h01) begin n_err++; $display("FAIL ramp_active: got %h required 01", active_voices); end
    for (int k = 0; k < 258; k++) q.push_back(model_mix());
    for (int k = 0; k < 258; k++) begin
      wait_strobe(ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL ramp_strobe[%0d]: got timeout required strobe", k); break; end
      exp = q.pop_front();
      if (int'(sample_out) !== exp) begin
        n_err++; $display("FAIL ramp[%0d]: got %0d required %0d", k, sample_out, exp);
      end
      if (k == 0 || k == 256) begin
        n_cmp++;
        if (int'(sample_out) !== -32512) begin n_err++; $display("FAIL ramp_start[%0d]: got %0d required -32512", k, sample_out); end
      end
      if (k == 1) begin
        n_cmp++;
        if (int'(sample_out) !== -32258) begin n_err++; $display("FAIL ramp_step: got %0d required -32258", sample_out); end
      end
    end
  endtask

  task automatic test_clamp();
    bit ok, d;
    int exp;
    do_reset();
    send_evt(1, 60, 127, 24'h010000, d);
    send_evt(1, 64, 127, 24'h010000, d);
    n_cmp++;
    if (active_voices !== 8'h03) begin n_err++; $display("FAIL clamp_active: got %h required 03", active_voices); end
    for (int k = 0; k < 3; k++) q.push_back(model_mix());
    for (int k = 0; k < 3; k++) begin
      wait_strobe(ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL clamp_strobe[%0d]: got timeout required strobe", k); break; end
      exp = q.pop_front();
      if (int'(sample_out) !== exp) begin n_err++; $display("FAIL clamp[%0d]: got %0d required %0d", k, sample_out, exp); end
      if (k == 0) begin
        n_cmp++;
        if (int'(sample_out) !== -32768) begin n_err++; $display("FAIL clamp_min: got %0d required -32768", sample_out); end
      end
    end
  endtask

  task automatic test_alloc_full();
    bit d;
    logic [NV-1:0] exp_act;
    bit exp_drop;
    do_reset();
    for (int i = 0; i < NV; i++) send_evt(1, 40 + i, 100, 24'h001000, d);
    n_cmp++;
    if (active_voices !== 8'hFF) begin n_err++; $display("FAIL full_active: got %h required FF", active_voices); end
`ifdef VOICE_STEAL_EN
    exp_drop = 1'b0;
    exp_act  = 8'hFC;
`else
    exp_drop = 1'b1;
    exp_act  = 8'hFF;
`endif
    send_evt(1, 90, 100, 24'h002000, d);
    n_cmp++;
    if (d !== exp_drop) begin n_err++; $display("FAIL full_dropped: got %b required %b", d, exp_drop); end
    @(negedge clk);
    n_cmp++;
    if (note_dropped !== 1'b0) begin n_err++; $display("FAIL drop_width: got %b required 0", note_dropped); end
    n_cmp++;
    if (active_voices !== 8'hFF) begin n_err++; $display("FAIL full_after9: got %h required FF", active_voices); end
    send_evt(1, 91, 100, 24'h003000, d);
    send_evt(0, 90, 0, 24'h0, d);
    send_evt(0, 91, 0, 24'h0, d);
    n_cmp++;
    if (active_voices !== exp_act) begin n_err++; $display("FAIL steal_victims: got %h required %h", active_voices, exp_act); end
  endtask

  task automatic test_note_off();
    bit ok, d;
    int exp;
    do_reset();
    send_evt(1, 60, 100, 24'h020000, d);
    send_evt(1, 64, 80,  24'h030000, d);
    send_evt(1, 67, 60,  24'h011000, d);
    n_cmp++;
    if (active_voices !== 8'h07) begin n_err++; $display("FAIL off_initial: got %h required 07", active_voices); end
    for (int k = 0; k < 2; k++) q.push_back(model_mix());
    for (int k = 0; k < 2; k++) begin
      wait_strobe(ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL off_strobe[%0d]: got timeout required strobe", k); end
      else begin
        exp = q.pop_front();
        if (int'(sample_out) !== exp) begin n_err++; $display("FAIL chord[%0d]: got %0d required %0d", k, sample_out, exp); end
      end
    end
    send_evt(0, 60, 0, 24'h0, d);
    n_cmp++;
    if (active_voices !== 8'h06) begin n_err++; $display("FAIL note_off: got %h required 06", active_voices); end
    send_evt(1, 64, 0, 24'h030000, d);
    n_cmp++;
    if (active_voices !== 8'h04) begin n_err++; $display("FAIL vel0_off: got %h required 04", active_voices); end
    send_evt(0, 99, 0, 24'h0, d);
    n_cmp++;
    if (active_voices !== 8'h04) begin n_err++; $display("FAIL absent_off: got %h required 04", active_voices); end
    send_evt(1, 67, 50, 24'h011000, d);
    n_cmp++;
    if (active_voices !== 8'h04) begin n_err++; $display("FAIL retrigger_slot: got %h required 04", active_voices); end
    for (int k = 0; k < 2; k++) q.push_back(model_mix());
    for (int k = 0; k < 2; k++) begin
      wait_strobe(ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL retrig_strobe[%0d]: got timeout required strobe", k); end
      else begin
        exp = q.pop_front();
        if (int'(sample_out) !== exp) begin n_err++; $display("FAIL retrig[%0d]: got %0d required %0d", k, sample_out, exp); end
        if (k == 0) begin
          n_cmp++;
          if (int'(sample_out) !== -12800) begin n_err++; $display("FAIL retrig_phase0: got %0d required -12800", sample_out); end
        end
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    bit ok, d;
    int k;
    do_reset();
    send_evt(1, 60, 127, 24'h010000, d);
    wait_strobe(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL midrst_sync: got timeout required strobe"); end
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (sample_out !== 16'sd0 || sample_valid !== 1'b0 || active_voices !== 8'h00 ||
        note_dropped !== 1'b0 || evt_ready !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_outputs: got out=%0d valid=%b act=%h drop=%b ready=%b required all 0",
               sample_out, sample_valid, active_voices, note_dropped, evt_ready);
    end
    reset = 1'b0;
    model_reset();
    k = 1;
    ok = 0;
    while (k <= 40 && !ok) begin
      @(negedge clk);
      if (sample_valid) ok = 1;
      else k++;
    end
    n_cmp++;
    if (!ok || k !== 26) begin n_err++; $display("FAIL midrst_first_strobe: got cycle %0d required 26", k); end
    n_cmp++;
    if (sample_out !== 16'sd0) begin n_err++; $display("FAIL midrst_sample: got %0d required 0", sample_out); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_ramp();
    test_clamp();
    test_alloc_full();
    test_note_off();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
